req_ack_4ph_tx_arb: RTL and testbench

Transmit-side controller for the 4-phase req/ack clock-domain crossing. It arbitrates N local val/rdy producers round-robin onto one shared req/ack channel and captures the winning word onto a stable data bus. It then sequences the full 4-phase cycle (req↑, ack↑, req↓, ack↓) against the synchronized ack returned by the receive side. It sits in the transmit clock domain, directly in front of the crossing.

---
 rtl/req_ack_4ph_tx_arb_pkg.sv | 10 +
 rtl/req_ack_4ph_tx_arb_if.sv | 27 ++
 rtl/req_ack_4ph_tx_arb_rr_arb.sv | 31 +++
 rtl/req_ack_4ph_tx_arb.sv | 121 ++++++++++++
 tb/tb_req_ack_4ph_tx_arb.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/req_ack_4ph_tx_arb_pkg.sv
// Shared 4-phase req/ack definitions, used by both the transmit and receive sides of the crossing.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_e;

endpackage

// File: rtl/req_ack_4ph_tx_arb_if.sv
// Local producer handshake plus crossing-side signals of the 4-phase transmit controller.
interface req_ack_4ph_tx_arb_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    val;
  logic [N-1:0]    rdy;
  logic [N*DW-1:0] din;
  logic            req;
  logic            ack;
  logic [DW-1:0]   dout;
  logic [IW-1:0]   gnt_id;
  logic            busy;
  logic            to_err;

  modport master (
    output val, din, ack,
    input  rdy, req, dout, gnt_id, busy, to_err
  );

  modport slave (
    input  val, din, ack,
    output rdy, req, dout, gnt_id, busy, to_err
  );
endinterface

// File: rtl/req_ack_4ph_tx_arb_rr_arb.sv
// Combinational round-robin picker: first requester after the last grant wins; the pointer is held by the parent.
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_vec,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found_s;

  // Scan from last+1 modulo N and take the first active request
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (en && !found_s && req_vec[(int'(last) + k) % N]) begin
        gnt[(int'(last) + k) % N] = 1'b1;
        idx                       = IW'((int'(last) + k) % N);
        found_s                   = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/req_ack_4ph_tx_arb.sv
// Transmit side of the 4-phase req/ack crossing: round-robin grant of N producers, stable data bus,
// full req/ack handshake against the synchronized ack, and an ack-timeout pulse.
module req_ack_4ph_tx_arb
  import req_ack_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int TO_W = 8
) (
  input logic                 clk_tx,
  input logic                 rst,
  req_ack_4ph_tx_arb_if.slave bus
);

  localparam int            IW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((1 << TO_W) - 2);

  logic              ack_meta_r;
  logic              ack_s_r;
  state_e            state_r;
  logic              req_r;
  logic              busy_r;
  logic              to_err_r;
  logic [DW-1:0]     dout_r;
  logic [IW-1:0]     gnt_id_r;
  logic [IW-1:0]     last_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic              arb_en_s;
  logic [N-1:0]      gnt_s;
  logic [IW-1:0]     win_s;
  logic              to_hit_s;

  // A stale ack left high by the far side blocks new grants until it falls
  assign arb_en_s = (state_r == IDLE) && !ack_s_r && !rst;
  assign to_hit_s = (to_cnt_r == TO_LAST);

  rr_arb #(.N(N), .IW(IW)) u_arb (
    .req_vec (bus.val),
    .last    (last_r),
    .en      (arb_en_s),
    .gnt     (gnt_s),
    .idx     (win_s)
  );

  assign bus.rdy    = gnt_s;
  assign bus.req    = req_r;
  assign bus.dout   = dout_r;
  assign bus.gnt_id = gnt_id_r;
  assign bus.busy   = busy_r;
  assign bus.to_err = to_err_r;

  // Two-flop synchronizer for the asynchronous ack
  always_ff @(posedge clk_tx or posedge rst) begin
    if (rst) begin
      ack_meta_r <= 1'b0;
      ack_s_r    <= 1'b0;
    end else begin
      ack_meta_r <= bus.ack;
      ack_s_r    <= ack_meta_r;
    end
  end

  // Handshake FSM with data capture and timeout; a timeout only reports, it never aborts the cycle
  always_ff @(posedge clk_tx or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      req_r    <= 1'b0;
      busy_r   <= 1'b0;
      to_err_r <= 1'b0;
      dout_r   <= '0;
      gnt_id_r <= '0;
      last_r   <= IW'(N - 1);
      to_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          to_err_r <= 1'b0;
          to_cnt_r <= '0;
          if (|gnt_s) begin
            dout_r   <= bus.din[int'(win_s)*DW +: DW];
            gnt_id_r <= win_s;
            last_r   <= win_s;
            req_r    <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= REQ;
          end
        end
        REQ: begin
          if (ack_s_r) begin
            req_r    <= 1'b0;
            state_r  <= REL;
            to_cnt_r <= '0;
            to_err_r <= 1'b0;
          end else begin
            to_cnt_r <= to_hit_s ? '0 : to_cnt_r + TO_W'(1);
            to_err_r <= to_hit_s;
          end
        end
        REL: begin
          if (!ack_s_r) begin
            busy_r   <= 1'b0;
            state_r  <= IDLE;
            to_cnt_r <= '0;
            to_err_r <= 1'b0;
          end else begin
            to_cnt_r <= to_hit_s ? '0 : to_cnt_r + TO_W'(1);
            to_err_r <= to_hit_s;
          end
        end
        default: begin
          state_r  <= IDLE;
          req_r    <= 1'b0;
          busy_r   <= 1'b0;
          to_err_r <= 1'b0;
          to_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_ack_4ph_tx_arb.sv
// Bench for req_ack_4ph_tx_arb: directed scenarios, a transaction-level model checked every cycle,
// and literal expectations for each scenario.
module tb_req_ack_4ph_tx_arb;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int TO_W = 4;
  localparam int TO_P = (1 << TO_W) - 1;

  logic clk_tx = 1'b0;
  logic rst    = 1'b1;

  req_ack_4ph_tx_arb_if #(.N(N), .DW(DW)) bus ();

  req_ack_4ph_tx_arb #(.N(N), .DW(DW), .TO_W(TO_W)) dut (
    .clk_tx (clk_tx),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_tx = ~clk_tx;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Producers: rem[i] words still to send, dval[i] the word currently offered
  int             rem[N];
  logic [DW-1:0]  dval[N];
  logic [N-1:0]   rdy_seen  = '0;
  int             rx_mode   = 0;     // 0: receiver echoes req, 1: ack forced to ack_force
  logic           ack_force = 1'b0;
  logic [3:0]     rh        = '0;
  int             act_gnts[$];

  function automatic bit all_sent();
    for (int i = 0; i < N; i++) if (rem[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin rem[i] = 0; dval[i] = 8'h00; end
    bus.val = '0;
    bus.din = '0;
    forever begin
      @(posedge clk_tx); #1;
      for (int i = 0; i < N; i++) begin
        if (rdy_seen[i] && rem[i] > 0) begin
          rem[i]--;
          dval[i] = dval[i] + 8'd1;
        end
        bus.val[i]          = (rem[i] > 0);
        bus.din[i*DW +: DW] = dval[i];
      end
      rdy_seen = '0;
    end
  end

  initial begin
    bus.ack = 1'b0;
    forever begin
      @(posedge clk_tx); #1;
      rh      = {rh[2:0], bus.req};
      bus.ack = (rx_mode == 0) ? rh[3] : ack_force;
    end
  end

  // Transaction-level model: phase 0 idle, 1 waiting for ack high, 2 waiting for ack low
  int            ph = 0;
  logic          m_a1 = 1'b0, m_as = 1'b0, m_req = 1'b0, m_toerr = 1'b0;
  logic [DW-1:0] m_dout = '0;
  int            m_gid = 0, m_last = N - 1, m_age = 0;

  initial begin
    forever begin
      @(posedge clk_tx or posedge rst);
      if (rst) begin
        ph = 0; m_a1 = 1'b0; m_as = 1'b0; m_req = 1'b0; m_toerr = 1'b0;
        m_dout = '0; m_gid = 0; m_last = N - 1; m_age = 0;
      end else begin
        m_toerr = 1'b0;
        if (ph == 0) begin
          if (!m_as && bus.val != '0) begin
            m_gid  = pick(bus.val, m_last);
            m_dout = bus.din[m_gid*DW +: DW];
            m_last = m_gid;
            m_req  = 1'b1;
            ph     = 1;
            m_age  = 0;
          end
        end else if (ph == 1 && m_as) begin
          m_req = 1'b0; ph = 2; m_age = 0;
        end else if (ph == 2 && !m_as) begin
          ph = 0;
        end else begin
          m_age++;
          m_toerr = (m_age % TO_P == 0);
        end
        m_as = m_a1;
        m_a1 = bus.ack;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial begin
    logic [N-1:0] er;
    forever begin
      @(negedge clk_tx);
      er = '0;
      if (!rst && ph == 0 && !m_as && bus.val != '0) er[pick(bus.val, m_last)] = 1'b1;
      chk("rdy",    32'(bus.rdy),    32'(er));
      chk("req",    32'(bus.req),    32'(m_req));
      chk("dout",   32'(bus.dout),   32'(m_dout));
      chk("gnt_id", 32'(bus.gnt_id), 32'(m_gid));
      chk("busy",   32'(bus.busy),   32'(ph != 0));
      chk("to_err", 32'(bus.to_err), 32'(m_toerr));
      rdy_seen = bus.rdy;
      if (bus.rdy != '0) act_gnts.push_back($clog2(bus.rdy));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_tx);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk_tx); #2;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    int c = 0;
    while (c < maxc && !(all_sent() && !bus.busy)) begin
      @(negedge clk_tx);
      c++;
    end
    chk(nm, 32'(c < maxc), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nto;
    int c;
    rst = 1'b1;
    cyc(3);
    chk("rst_req",  32'(bus.req),    32'd0);
    chk("rst_busy", 32'(bus.busy),   32'd0);
    chk("rst_dout", 32'(bus.dout),   32'd0);
    chk("rst_gid",  32'(bus.gnt_id), 32'd0);
    chk("rst_toe",  32'(bus.to_err), 32'd0);
    rst = 1'b0;

    // Single transfer from requester 0 with an echoing receiver
    act_gnts.delete();
    dval[0] = 8'hA5;
    rem[0]  = 1;
    wait_done(100, "t1_timeout");
    chk("t1_pulses", 32'(act_gnts.size()), 32'd1);
    chk("t1_dout",   32'(bus.dout),        32'hA5);
    chk("t1_gid",    32'(bus.gnt_id),      32'd0);

    // All requesters hold val: strict rotation 0,1,2,3 repeated
    do_reset();
    act_gnts.delete();
    for (int i = 0; i < N; i++) begin dval[i] = 8'(8'h10 * (i + 1)); rem[i] = 5; end
    wait_done(2000, "t2_timeout");
    chk("t2_pulses", 32'(act_gnts.size()), 32'd20);
    for (int k = 0; k < act_gnts.size(); k++) chk("t2_order", 32'(act_gnts[k]), 32'(k % N));

    // Stale ack high across reset release blocks grants until it falls
    rx_mode   = 1;
    ack_force = 1'b1;
    do_reset();
    cyc(4);
    act_gnts.delete();
    dval[1] = 8'h5A;
    rem[1]  = 1;
    cyc(8);
    chk("t3_nogrant", 32'(act_gnts.size()), 32'd0);
    chk("t3_idle",    32'(bus.busy),        32'd0);
    ack_force = 1'b0;
    cyc(1);
    rx_mode = 0;
    wait_done(100, "t3_timeout");
    chk("t3_pulses", 32'(act_gnts.size()), 32'd1);
    if (act_gnts.size() > 0) chk("t3_winner", 32'(act_gnts[0]), 32'd1);
    chk("t3_dout", 32'(bus.dout), 32'h5A);

    // ack never returns: timeout pulses every 2^TO_W-1 cycles, transfer held
    rx_mode   = 1;
    ack_force = 1'b0;
    dval[0]   = 8'h3C;
    rem[0]    = 1;
    c = 0;
    while (c < 50 && !bus.busy) begin @(negedge clk_tx); c++; end
    chk("t4_start", 32'(c < 50), 32'd1);
    nto = 0;
    repeat (45) begin
      @(negedge clk_tx);
      if (bus.to_err) nto++;
    end
    chk("t4_toerr_cnt", 32'(nto),      32'd3);
    chk("t4_req",       32'(bus.req),  32'd1);
    chk("t4_dout",      32'(bus.dout), 32'h3C);

    // Reset in the middle of REQ drops everything at once; requester 0 leads afterwards
    @(posedge clk_tx); #2;
    rst = 1'b1;
    #1;
    chk("t5_req",  32'(bus.req),  32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_dout", 32'(bus.dout), 32'd0);
    for (int i = 0; i < N; i++) begin dval[i] = 8'(8'hC0 + i); rem[i] = 1; end
    rx_mode = 0;
    cyc(2);
    act_gnts.delete();
    rst = 1'b0;
    wait_done(500, "t5_timeout");
    chk("t5_pulses", 32'(act_gnts.size()), 32'd4);
    for (int k = 0; k < act_gnts.size(); k++) chk("t5_order", 32'(act_gnts[k]), 32'(k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
